// File: rtl/sseg_pkg.sv
// ============================================================================
// Module : sseg_pkg
// Brief  : Shared types and helpers for the seven-segment scan/decode stages.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sseg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NIBBLE_W   = 4;
    localparam int VALUE_W    = NUM_DIGITS * NIBBLE_W;

    typedef logic [NUM_DIGITS-1:0] digit_sel_t;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_idx_t;

    typedef enum logic [0:0] {
        PEND_IDLE = 1'b0,
        PEND_FULL = 1'b1
    } pend_state_t;

    function automatic digit_sel_t onehot4(input logic [1:0] idx);
        digit_sel_t sel;
        sel      = '0;
        sel[idx] = 1'b1;
        return sel;
    endfunction

    function automatic logic [NIBBLE_W-1:0] nibble_at(input logic [VALUE_W-1:0] value,
                                                      input logic [1:0]         idx);
        return value[{idx, 2'b00} +: NIBBLE_W];
    endfunction

    // True when digit idx and every more-significant digit are zero; digit 0 never qualifies.
    function automatic logic upper_zero(input logic [VALUE_W-1:0] value,
                                        input logic [1:0]         idx);
        logic res;
        case (idx)
            2'd1:    res = (value[15:4]  == 12'h000);
            2'd2:    res = (value[15:8]  == 8'h00);
            2'd3:    res = (value[15:12] == 4'h0);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ssegment_scan_if.sv
// ============================================================================
// Module : ssegment_scan_if
// Brief  : Control/value inputs and scan outputs of the seven-segment scanner.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ssegment_scan_if;
    import sseg_pkg::*;

    logic                enable;
    logic [VALUE_W-1:0]  value_in;
    logic                load;
    digit_sel_t          ds;
    logic [NIBBLE_W-1:0] data;
    logic                frame_done;
    logic                pending;

    modport master (
        output enable, value_in, load,
        input  ds, data, frame_done, pending
    );

    modport slave (
        input  enable, value_in, load,
        output ds, data, frame_done, pending
    );
endinterface

`default_nettype wire

// File: rtl/sseg_refresh_div.sv
// ============================================================================
// Module : sseg_refresh_div
// Brief  : Digit-slot divider; counts 0..REFRESH_DIV-1 and flags the last cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sseg_refresh_div #(
    parameter int REFRESH_DIV = 50000
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  en_i,
    output logic tc_o
);

    localparam int               DIV_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] C_TERMINAL = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic             at_term;

    assign at_term = (div_cnt_q == C_TERMINAL);
    assign tc_o    = en_i && at_term;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (en_i) begin
            div_cnt_d = at_term ? '0 : div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ssegment_scan.sv
// ============================================================================
// Module : ssegment_scan
// Brief  : 4-digit hex scanner with frame-aligned double-buffered value update.
//          Optional macro SSEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ssegment_scan
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  wire             clk,
    input  wire             rst_n,
    ssegment_scan_if.slave  bus
);

    logic                tc;
    logic                boundary;
    logic                lz_blank;

    digit_idx_t          idx_q,    idx_d;
    logic [VALUE_W-1:0]  shadow_q, shadow_d;
    logic [VALUE_W-1:0]  disp_q,   disp_d;
    pend_state_t         pend_q,   pend_d;
    logic                wrap_q;

    digit_sel_t          ds_q,     ds_d;
    logic [NIBBLE_W-1:0] data_q,   data_d;
    logic                frame_done_q;

    sseg_refresh_div #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_refresh_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (bus.enable),
        .tc_o  (tc)
    );

    assign boundary = tc && (idx_q == DIG3);

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    assign lz_blank = upper_zero(disp_q, idx_q);
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        idx_d = idx_q;
        if (tc) begin
            case (idx_q)
                DIG0:    idx_d = DIG1;
                DIG1:    idx_d = DIG2;
                DIG2:    idx_d = DIG3;
                default: idx_d = DIG0;
            endcase
        end
    end

    // A load landing on the frame boundary bypasses the shadow and never raises pending.
    always_comb begin
        shadow_d = shadow_q;
        disp_d   = disp_q;
        pend_d   = pend_q;
        if (bus.load) begin
            shadow_d = bus.value_in;
        end
        if (boundary && bus.load) begin
            disp_d = bus.value_in;
            pend_d = PEND_IDLE;
        end else if (bus.load) begin
            pend_d = PEND_FULL;
        end else if (boundary && (pend_q == PEND_FULL)) begin
            disp_d = shadow_q;
            pend_d = PEND_IDLE;
        end
    end

    // Outputs present the slot state held before this edge, so each digit shows
    // for exactly REFRESH_DIV cycles starting the cycle after reset release.
    always_comb begin
        ds_d   = '0;
        data_d = '0;
        if (bus.enable) begin
            ds_d   = lz_blank ? digit_sel_t'('0) : onehot4(idx_q);
            data_d = nibble_at(disp_q, idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q        <= DIG0;
            shadow_q     <= '0;
            disp_q       <= '0;
            pend_q       <= PEND_IDLE;
            wrap_q       <= 1'b0;
            ds_q         <= '0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            wrap_q       <= boundary;
            ds_q         <= ds_d;
            data_q       <= data_d;
            frame_done_q <= wrap_q;
        end
    end

    assign bus.ds         = ds_q;
    assign bus.data       = data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.pending    = (pend_q == PEND_FULL);

endmodule

`default_nettype wire

// File: tb/tb_ssegment_scan.sv
// ============================================================================
// Module : tb_ssegment_scan
// Brief  : Directed scoreboard bench for ssegment_scan with REFRESH_DIV=4.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ssegment_scan;
    import sseg_pkg::*;

    localparam int REFRESH_DIV = 4;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] tag;
        logic [3:0] ds;
        logic [3:0] data;
        logic       fd;
        logic       pend;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   test_id = 0;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    exp_t sb_q[$];

    ssegment_scan_if sif ();

    ssegment_scan #(
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected select for a digit whose own and higher nibbles are all zero.
    function automatic digit_sel_t lzb(input digit_sel_t d);
        return LZB ? 4'b0000 : d;
    endfunction

    task automatic step(input int n, input digit_sel_t eds, input logic [3:0] edata,
                        input logic efd, input logic epend);
        exp_t e;
        repeat (n) begin
            @(posedge clk);
            #1;
            e.tag  = 8'(test_id);
            e.ds   = eds;
            e.data = edata;
            e.fd   = efd;
            e.pend = epend;
            sb_q.push_back(e);
        end
    endtask

    task automatic load_val(input logic [15:0] v);
        sif.load     = 1'b1;
        sif.value_in = v;
    endtask

    task automatic check_reset_state();
        checks++;
        if (sif.ds !== 4'b0000 || sif.data !== 4'h0 ||
            sif.frame_done !== 1'b0 || sif.pending !== 1'b0) begin
            errors++;
            $display("FAIL test%0d cyc%0d: reset state ds=%b data=%h frame_done=%b pending=%b, want all zero",
                     test_id, cyc, sif.ds, sif.data, sif.frame_done, sif.pending);
        end
    endtask

    task automatic wait_frame_done(input int max_cyc);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        checks++;
        @(posedge clk);
        while (!seen && n < max_cyc) begin
            @(negedge clk);
            n++;
            if (sif.frame_done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            errors++;
            $display("FAIL test%0d cyc%0d: frame_done not seen within %0d cycles",
                     test_id, cyc, max_cyc);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (sif.ds !== e.ds || sif.data !== e.data ||
                    sif.frame_done !== e.fd || sif.pending !== e.pend) begin
                    errors++;
                    $display("FAIL test%0d cyc%0d: got ds=%b data=%h frame_done=%b pending=%b, want ds=%b data=%h frame_done=%b pending=%b",
                             e.tag, cyc, sif.ds, sif.data, sif.frame_done, sif.pending,
                             e.ds, e.data, e.fd, e.pend);
                end
            end
        end
    end

    initial begin : stimulus
        rst_n        = 1'b0;
        sif.enable   = 1'b1;
        sif.load     = 1'b0;
        sif.value_in = 16'h0000;

        // 1: reset then scan of an all-zero display
        test_id = 1;
        step(3, 4'b0000, 4'h0, 1'b0, 1'b0);
        check_reset_state();
        rst_n = 1'b1;
        step(4, 4'b0001, 4'h0, 1'b0, 1'b0);
        step(4, lzb(4'b0010), 4'h0, 1'b0, 1'b0);
        step(4, lzb(4'b0100), 4'h0, 1'b0, 1'b0);
        step(4, lzb(4'b1000), 4'h0, 1'b0, 1'b0);
        step(1, 4'b0001, 4'h0, 1'b1, 1'b0);
        step(3, 4'b0001, 4'h0, 1'b0, 1'b0);

        // 2: load mid-slot of digit 1, applied at the next frame boundary
        test_id = 2;
        step(1, lzb(4'b0010), 4'h0, 1'b0, 1'b0);
        load_val(16'hA3C5);
        step(1, lzb(4'b0010), 4'h0, 1'b0, 1'b1);
        sif.load = 1'b0;
        step(2, lzb(4'b0010), 4'h0, 1'b0, 1'b1);
        step(4, lzb(4'b0100), 4'h0, 1'b0, 1'b1);
        step(3, lzb(4'b1000), 4'h0, 1'b0, 1'b1);
        step(1, lzb(4'b1000), 4'h0, 1'b0, 1'b0);
        step(1, 4'b0001, 4'h5, 1'b1, 1'b0);
        step(3, 4'b0001, 4'h5, 1'b0, 1'b0);
        step(4, 4'b0010, 4'hC, 1'b0, 1'b0);
        step(4, 4'b0100, 4'h3, 1'b0, 1'b0);
        step(3, 4'b1000, 4'hA, 1'b0, 1'b0);

        // 3a: load on the idx=3 terminal cycle goes straight to the display
        test_id = 3;
        load_val(16'h1234);
        step(1, 4'b1000, 4'hA, 1'b0, 1'b0);
        sif.load = 1'b0;
        step(1, 4'b0001, 4'h4, 1'b1, 1'b0);
        step(3, 4'b0001, 4'h4, 1'b0, 1'b0);
        step(4, 4'b0010, 4'h3, 1'b0, 1'b0);
        step(4, 4'b0100, 4'h2, 1'b0, 1'b0);
        step(4, 4'b1000, 4'h1, 1'b0, 1'b0);

        // 3b: two loads in one frame, last one wins
        test_id = 4;
        step(1, 4'b0001, 4'h4, 1'b1, 1'b0);
        load_val(16'h1111);
        step(1, 4'b0001, 4'h4, 1'b0, 1'b1);
        sif.load = 1'b0;
        step(2, 4'b0001, 4'h4, 1'b0, 1'b1);
        step(4, 4'b0010, 4'h3, 1'b0, 1'b1);
        load_val(16'h2222);
        step(1, 4'b0100, 4'h2, 1'b0, 1'b1);
        sif.load = 1'b0;
        step(3, 4'b0100, 4'h2, 1'b0, 1'b1);
        step(3, 4'b1000, 4'h1, 1'b0, 1'b1);
        step(1, 4'b1000, 4'h1, 1'b0, 1'b0);
        step(1, 4'b0001, 4'h2, 1'b1, 1'b0);
        step(3, 4'b0001, 4'h2, 1'b0, 1'b0);
        step(4, 4'b0010, 4'h2, 1'b0, 1'b0);
        step(4, 4'b0100, 4'h2, 1'b0, 1'b0);
        step(4, 4'b1000, 4'h2, 1'b0, 1'b0);

        // 4: enable dropped after one cycle of digit 2
        test_id = 5;
        step(1, 4'b0001, 4'h2, 1'b1, 1'b0);
        step(3, 4'b0001, 4'h2, 1'b0, 1'b0);
        step(4, 4'b0010, 4'h2, 1'b0, 1'b0);
        step(1, 4'b0100, 4'h2, 1'b0, 1'b0);
        sif.enable = 1'b0;
        step(10, 4'b0000, 4'h0, 1'b0, 1'b0);
        sif.enable = 1'b1;
        step(3, 4'b0100, 4'h2, 1'b0, 1'b0);
        step(4, 4'b1000, 4'h2, 1'b0, 1'b0);

        // 5: reset during digit 3 with a pending value
        test_id = 6;
        step(1, 4'b0001, 4'h2, 1'b1, 1'b0);
        load_val(16'h5678);
        step(1, 4'b0001, 4'h2, 1'b0, 1'b1);
        sif.load = 1'b0;
        step(2, 4'b0001, 4'h2, 1'b0, 1'b1);
        step(4, 4'b0010, 4'h2, 1'b0, 1'b1);
        step(4, 4'b0100, 4'h2, 1'b0, 1'b1);
        step(2, 4'b1000, 4'h2, 1'b0, 1'b1);
        rst_n = 1'b0;
        step(3, 4'b0000, 4'h0, 1'b0, 1'b0);
        check_reset_state();
        rst_n = 1'b1;

        // 6: display 0x0070 (leading-zero blanking when enabled)
        test_id = 7;
        step(1, 4'b0001, 4'h0, 1'b0, 1'b0);
        load_val(16'h0070);
        step(1, 4'b0001, 4'h0, 1'b0, 1'b1);
        sif.load = 1'b0;
        step(2, 4'b0001, 4'h0, 1'b0, 1'b1);
        step(4, lzb(4'b0010), 4'h0, 1'b0, 1'b1);
        step(4, lzb(4'b0100), 4'h0, 1'b0, 1'b1);
        step(3, lzb(4'b1000), 4'h0, 1'b0, 1'b1);
        step(1, lzb(4'b1000), 4'h0, 1'b0, 1'b0);
        step(1, 4'b0001, 4'h0, 1'b1, 1'b0);
        step(3, 4'b0001, 4'h0, 1'b0, 1'b0);
        step(4, 4'b0010, 4'h7, 1'b0, 1'b0);
        step(4, lzb(4'b0100), 4'h0, 1'b0, 1'b0);
        step(4, lzb(4'b1000), 4'h0, 1'b0, 1'b0);
        step(1, 4'b0001, 4'h0, 1'b1, 1'b0);

        wait_frame_done(20);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
